recorder_ctrl: RTL

Top-level sequencer for the lab3 audio recorder.
- Turns debounced one-cycle key pulses into the record/play/pause state, the elapsed-seconds timer, and the playback speed setting.
- Drives the seven-segment display decoder (state, timer, speed status, speed) directly.
- Drives the enable signals consumed by the audio recorder/player datapath.

---
 rtl/recorder_pkg.sv | 19 +
 rtl/recorder_ctrl_sec_tick_gen.sv | 49 ++++
 rtl/recorder_ctrl.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/recorder_pkg.sv
// Shared types for the lab3 recorder sequencer.
package recorder_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd1,
        PLAY   = 3'd2,
        RECORD = 3'd3,
        PAUSE  = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        NORMAL = 2'd0,
        FAST   = 2'd1,
        SLOW   = 2'd2
    } spd_stat_t;

    localparam logic [3:0] SPD_MIN = 4'd2;

endpackage

// File: rtl/recorder_ctrl_sec_tick_gen.sv
// Seconds tick: fractional accumulator toward CLK_HZ plus slow-mode divider.
module sec_tick_gen
    import recorder_pkg::*;
#(
    parameter int CLK_HZ = 12000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       clr,
    input  spd_stat_t  stat,
    input  logic [3:0] speed,
    output logic       tick
);

    localparam int AW = $clog2(CLK_HZ) + 4;
    localparam logic [AW-1:0] HZ = AW'(CLK_HZ);

    logic [AW-1:0] acc;
    logic [AW-1:0] inc;
    logic [AW-1:0] sum;
    logic [3:0]    div;
    logic          slot;

    always_comb begin
        // >= keeps the divider sane if speed drops mid-count
        slot = (div >= speed - 4'd1);
        case (stat)
            FAST:    inc = AW'(speed);
            SLOW:    inc = slot ? AW'(1) : '0;
            default: inc = AW'(1);
        endcase
        sum  = acc + inc;
        tick = en && !clr && (sum >= HZ);
    end

    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            acc <= '0;
            div <= '0;
        end else if (en) begin
            acc <= tick ? sum - HZ : sum;
            div <= (stat == SLOW && !slot) ? div + 4'd1 : 4'd0;
        end else begin
            div <= '0;
        end
    end

endmodule

// File: rtl/recorder_ctrl.sv
// Recorder sequencer: key pulses to state, elapsed timer and playback speed.
module recorder_ctrl
    import recorder_pkg::*;
#(
    parameter int CLK_HZ    = 12000000,
    parameter int MAX_SEC   = 31,
    parameter int MAX_SPEED = 8
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_key_play,
    input  logic       i_key_rec,
    input  logic       i_key_pause,
    input  logic       i_key_stop,
    input  logic       i_key_up,
    input  logic       i_key_down,
    input  logic       i_mem_full,
    input  logic       i_play_end,
    output logic [2:0] o_state,
    output logic [4:0] o_timer,
    output logic [1:0] o_speed_stat,
    output logic [3:0] o_speed,
    output logic       o_rec_en,
    output logic       o_play_en,
    output logic [4:0] o_rec_len
);

    localparam logic [4:0] SEC_MAX = 5'(MAX_SEC);
    localparam logic [3:0] SPD_MAX = 4'(MAX_SPEED);

    state_t     state, nstate, resume, nresume;
    spd_stat_t  stat, nstat;
    logic [3:0] speed, nspeed;
    logic [4:0] timer, ntimer, tnext;
    logic [4:0] rec_len, nlen;
    logic       rec_en, play_en, tick;

    sec_tick_gen #(.CLK_HZ(CLK_HZ)) u_tick (
        .clk   (i_clk),
        .rst_n (i_rst_n),
        .en    (state == RECORD || state == PLAY),
        .clr   (state == IDLE),
        .stat  (stat),
        .speed (speed),
        .tick  (tick)
    );

    assign tnext = (timer == 5'd31) ? timer : timer + 5'd1;

    always_comb begin
        nstate  = state;
        nresume = resume;
        ntimer  = timer;
        nlen    = rec_len;
        unique case (state)
            IDLE: begin
                if (i_key_rec) begin
                    nstate = RECORD;
                    ntimer = '0;
                end else if (i_key_play && rec_len != 5'd0) begin
                    nstate = PLAY;
                    ntimer = '0;
                end
            end
            RECORD: begin
                if (i_key_stop || i_mem_full) begin
                    nstate = IDLE;
                    nlen   = timer;
                    ntimer = '0;
                end else if (i_key_pause) begin
                    nstate  = PAUSE;
                    nresume = RECORD;
                end else if (tick && tnext == SEC_MAX) begin
                    nstate = IDLE;
                    nlen   = SEC_MAX;
                    ntimer = '0;
                end else if (tick) begin
                    ntimer = tnext;
                end
            end
            PLAY: begin
                if (i_key_stop) begin
                    nstate = IDLE;
                    ntimer = '0;
                end else if (i_key_pause) begin
                    nstate  = PAUSE;
                    nresume = PLAY;
                end else if (i_play_end || (tick && tnext == rec_len)) begin
                    nstate = IDLE;
                    ntimer = '0;
                end else if (tick) begin
                    ntimer = tnext;
                end
            end
            PAUSE: begin
                if (i_key_stop) begin
                    nstate = IDLE;
                    ntimer = '0;
                    if (resume == RECORD) nlen = timer;
                end else if (i_key_pause || i_key_play) begin
                    nstate = resume;
                end
            end
            default: nstate = IDLE;
        endcase
    end

    always_comb begin
        nstat  = stat;
        nspeed = speed;
        if (i_key_up && !i_key_down) begin
            case (stat)
                NORMAL: begin nstat = FAST; nspeed = SPD_MIN; end
                FAST: if (speed < SPD_MAX) nspeed = speed + 4'd1;
                default: begin
                    if (speed <= SPD_MIN) begin
                        nstat  = NORMAL;
                        nspeed = 4'd1;
                    end else begin
                        nspeed = speed - 4'd1;
                    end
                end
            endcase
        end else if (i_key_down && !i_key_up) begin
            case (stat)
                NORMAL: begin nstat = SLOW; nspeed = SPD_MIN; end
                SLOW: if (speed < SPD_MAX) nspeed = speed + 4'd1;
                default: begin
                    if (speed <= SPD_MIN) begin
                        nstat  = NORMAL;
                        nspeed = 4'd1;
                    end else begin
                        nspeed = speed - 4'd1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state   <= IDLE;
            resume  <= IDLE;
            timer   <= '0;
            rec_len <= '0;
            stat    <= NORMAL;
            speed   <= 4'd1;
            rec_en  <= 1'b0;
            play_en <= 1'b0;
        end else begin
            state   <= nstate;
            resume  <= nresume;
            timer   <= ntimer;
            rec_len <= nlen;
            stat    <= nstat;
            speed   <= nspeed;
            rec_en  <= (nstate == RECORD);
            play_en <= (nstate == PLAY);
        end
    end

    assign o_state      = state;
    assign o_timer      = timer;
    assign o_speed_stat = stat;
    assign o_speed      = speed;
    assign o_rec_en     = rec_en;
    assign o_play_en    = play_en;
    assign o_rec_len    = rec_len;

endmodule
